// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serializes I-cache refill and data-memory requests
// onto one external memory bus, with a per-transaction ack watchdog.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic            o_IC_MemReady,
  output logic [XLEN-1:0] o_IC_Data,
  input  logic            i_DM_MemRead,
  input  logic            i_DM_Wen,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [3:0]      i_DM_byte_en,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_MEM_req,
  output logic            o_MEM_we,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wdata,
  output logic [3:0]      o_MEM_byte_en,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ack,
  output logic            o_bus_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUS_I  = 3'd1;
  localparam logic [2:0] S_BUS_D  = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             last_dm_q, last_dm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             ic_rdy_q, ic_rdy_d;
  logic             dm_rdy_q, dm_rdy_d;
  logic [XLEN-1:0]  ic_data_q, ic_data_d;
  logic [XLEN-1:0]  dm_data_q, dm_data_d;
  logic             bus_err_q, bus_err_d;
  logic             dm_req;

  assign dm_req = i_DM_MemRead | i_DM_Wen;

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    ic_data_d   = ic_data_q;
    dm_data_d   = dm_data_q;
    ic_rdy_d    = 1'b0;
    dm_rdy_d    = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the side that did not win last time gets the bus.
        if (i_IC_DataReq && (!dm_req || last_dm_q)) begin
          state_d     = S_BUS_I;
          last_dm_d   = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_IC_Addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end else if (dm_req) begin
          state_d     = S_BUS_D;
          last_dm_d   = 1'b1;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = i_DM_Wen;
          mem_addr_d  = i_DM_Addr;
          mem_wdata_d = i_DM_Wd;
          mem_be_d    = i_DM_byte_en;
        end
      end
      S_BUS_I, S_BUS_D: begin
        if (i_MEM_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == S_BUS_I) begin
            ic_data_d = i_MEM_rdata;
            ic_rdy_d  = 1'b1;
            state_d   = S_RESP_I;
          end else begin
            // Writes leave the last read value in place.
            if (!mem_we_q) dm_data_d = i_MEM_rdata;
            dm_rdy_d = 1'b1;
            state_d  = S_RESP_D;
          end
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == S_BUS_I) begin
            ic_data_d = '0;
            ic_rdy_d  = 1'b1;
            state_d   = S_RESP_I;
          end else begin
            dm_data_d = '0;
            dm_rdy_d  = 1'b1;
            state_d   = S_RESP_D;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP_I, S_RESP_D: state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      last_dm_q   <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      ic_rdy_q    <= 1'b0;
      dm_rdy_q    <= 1'b0;
      ic_data_q   <= '0;
      dm_data_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      ic_rdy_q    <= ic_rdy_d;
      dm_rdy_q    <= dm_rdy_d;
      ic_data_q   <= ic_data_d;
      dm_data_q   <= dm_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_MEM_req       = mem_req_q;
  assign o_MEM_we        = mem_we_q;
  assign o_MEM_addr      = mem_addr_q;
  assign o_MEM_wdata     = mem_wdata_q;
  assign o_MEM_byte_en   = mem_be_q;
  assign o_IC_MemReady   = ic_rdy_q;
  assign o_DM_data_ready = dm_rdy_q;
  assign o_IC_Data       = ic_data_q;
  assign o_DM_ReadData   = dm_data_q;
  assign o_bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int TO   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_IC_DataReq;
  logic [XLEN-1:0] i_IC_Addr;
  logic            o_IC_MemReady;
  logic [XLEN-1:0] o_IC_Data;
  logic            i_DM_MemRead;
  logic            i_DM_Wen;
  logic [XLEN-1:0] i_DM_Addr;
  logic [XLEN-1:0] i_DM_Wd;
  logic [3:0]      i_DM_byte_en;
  logic            o_DM_data_ready;
  logic [XLEN-1:0] o_DM_ReadData;
  logic            o_MEM_req;
  logic            o_MEM_we;
  logic [XLEN-1:0] o_MEM_addr;
  logic [XLEN-1:0] o_MEM_wdata;
  logic [3:0]      o_MEM_byte_en;
  logic [XLEN-1:0] i_MEM_rdata;
  logic            i_MEM_ack;
  logic            o_bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_IC_DataReq(i_IC_DataReq), .i_IC_Addr(i_IC_Addr),
    .o_IC_MemReady(o_IC_MemReady), .o_IC_Data(o_IC_Data),
    .i_DM_MemRead(i_DM_MemRead), .i_DM_Wen(i_DM_Wen), .i_DM_Addr(i_DM_Addr),
    .i_DM_Wd(i_DM_Wd), .i_DM_byte_en(i_DM_byte_en),
    .o_DM_data_ready(o_DM_data_ready), .o_DM_ReadData(o_DM_ReadData),
    .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
    .o_MEM_wdata(o_MEM_wdata), .o_MEM_byte_en(o_MEM_byte_en),
    .i_MEM_rdata(i_MEM_rdata), .i_MEM_ack(i_MEM_ack), .o_bus_err(o_bus_err)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [136:0] all_outs();
    return {o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en,
            o_IC_MemReady, o_DM_data_ready, o_IC_Data, o_DM_ReadData, o_bus_err};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    i_IC_DataReq = 1'b0; i_IC_Addr = '0;
    i_DM_MemRead = 1'b0; i_DM_Wen = 1'b0; i_DM_Addr = '0; i_DM_Wd = '0; i_DM_byte_en = '0;
    i_MEM_ack = 1'b0; i_MEM_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({o_MEM_req, o_IC_MemReady, o_DM_data_ready, o_bus_err} !== 4'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=0000",
                           {o_MEM_req, o_IC_MemReady, o_DM_data_ready, o_bus_err});
    end
  endtask

  task automatic test_lone_i;
    do_reset();
    i_IC_DataReq = 1'b1; i_IC_Addr = 32'h0000_0100;
    tick();
    checks++;
    if ({o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_byte_en} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      failures++; $display("FAIL lone_i_bus got=%h exp=%h",
        {o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_byte_en}, {1'b1, 1'b0, 32'h100, 4'hF});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h0000_0013;
    tick();
    i_MEM_ack = 1'b0; i_IC_DataReq = 1'b0;
    checks++;
    if ({o_IC_MemReady, o_DM_data_ready, o_IC_Data, o_MEM_req} !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
      failures++; $display("FAIL lone_i_ready got=%h exp=%h",
        {o_IC_MemReady, o_DM_data_ready, o_IC_Data, o_MEM_req}, {1'b1, 1'b0, 32'h13, 1'b0});
    end
    tick();
    checks++;
    if ({o_IC_MemReady, o_MEM_req} !== 2'b00) begin
      failures++; $display("FAIL lone_i_pulse got=%b exp=00", {o_IC_MemReady, o_MEM_req});
    end
  endtask

  task automatic test_tie;
    do_reset();
    i_IC_DataReq = 1'b1; i_IC_Addr = 32'h200;
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h8000_0000;
    tick();
    checks++;
    if ({o_MEM_req, o_MEM_addr} !== {1'b1, 32'h200}) begin
      failures++; $display("FAIL tie_first_i got=%h exp=%h", {o_MEM_req, o_MEM_addr}, {1'b1, 32'h200});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h1111_0001;
    tick();
    i_MEM_ack = 1'b0;
    checks++;
    if ({o_IC_MemReady, o_DM_data_ready, o_IC_Data} !== {2'b10, 32'h1111_0001}) begin
      failures++; $display("FAIL tie_i_ready got=%h exp=%h",
        {o_IC_MemReady, o_DM_data_ready, o_IC_Data}, {2'b10, 32'h1111_0001});
    end
    i_IC_Addr = 32'h204;
    tick();
    tick();
    checks++;
    if ({o_MEM_req, o_MEM_we, o_MEM_addr} !== {2'b10, 32'h8000_0000}) begin
      failures++; $display("FAIL tie_then_d got=%h exp=%h", {o_MEM_req, o_MEM_we, o_MEM_addr},
                           {2'b10, 32'h8000_0000});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h2222_0002;
    tick();
    i_MEM_ack = 1'b0;
    checks++;
    if ({o_IC_MemReady, o_DM_data_ready, o_DM_ReadData} !== {2'b01, 32'h2222_0002}) begin
      failures++; $display("FAIL tie_d_ready got=%h exp=%h",
        {o_IC_MemReady, o_DM_data_ready, o_DM_ReadData}, {2'b01, 32'h2222_0002});
    end
    i_DM_Addr = 32'h8000_0004;
    tick(); tick();
    checks++;
    if ({o_MEM_req, o_MEM_addr} !== {1'b1, 32'h204}) begin
      failures++; $display("FAIL tie_alternate_i got=%h exp=%h", {o_MEM_req, o_MEM_addr}, {1'b1, 32'h204});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h3333_0003;
    tick();
    i_MEM_ack = 1'b0; i_IC_DataReq = 1'b0;
    tick(); tick();
    checks++;
    if ({o_MEM_req, o_MEM_addr} !== {1'b1, 32'h8000_0004}) begin
      failures++; $display("FAIL tie_alternate_d got=%h exp=%h", {o_MEM_req, o_MEM_addr},
                           {1'b1, 32'h8000_0004});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h4444_0004;
    tick();
    i_MEM_ack = 1'b0; i_DM_MemRead = 1'b0;
    tick();
  endtask

  task automatic test_write;
    do_reset();
    i_DM_Wen = 1'b1; i_DM_MemRead = 1'b1; i_DM_Addr = 32'h10;
    i_DM_Wd = 32'hDEAD_BEEF; i_DM_byte_en = 4'b0011;
    tick();
    checks++;
    if ({o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en} !==
        {2'b11, 32'h10, 32'hDEAD_BEEF, 4'b0011}) begin
      failures++; $display("FAIL write_bus got=%h exp=%h",
        {o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en},
        {2'b11, 32'h10, 32'hDEAD_BEEF, 4'b0011});
    end
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h1234_5678;
    tick();
    i_MEM_ack = 1'b0; i_DM_Wen = 1'b0; i_DM_MemRead = 1'b0;
    checks++;
    if ({o_DM_data_ready, o_IC_MemReady, o_MEM_req, o_MEM_we, o_DM_ReadData} !== {4'b1000, 32'h0}) begin
      failures++; $display("FAIL write_ready got=%h exp=%h",
        {o_DM_data_ready, o_IC_MemReady, o_MEM_req, o_MEM_we, o_DM_ReadData}, {4'b1000, 32'h0});
    end
    tick();
    checks++;
    if (o_DM_data_ready !== 1'b0) begin
      failures++; $display("FAIL write_pulse got=%b exp=0", o_DM_data_ready);
    end
  endtask

  task automatic test_timeout;
    int hi;
    bit done;
    hi = 0; done = 1'b0;
    do_reset();
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h40;
    tick();
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'hCAFE_F00D;
    tick();
    i_MEM_ack = 1'b0; i_DM_MemRead = 1'b0;
    checks++;
    if ({o_DM_data_ready, o_DM_ReadData} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL timeout_preload got=%h exp=%h", {o_DM_data_ready, o_DM_ReadData},
                           {1'b1, 32'hCAFE_F00D});
    end
    tick();
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h44;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (o_MEM_req) hi++;
      else if (hi > 0) begin
        done = 1'b1;
        i_DM_MemRead = 1'b0;
        checks++;
        if ({o_DM_data_ready, o_bus_err, o_IC_MemReady, o_DM_ReadData} !== {3'b110, 32'h0}) begin
          failures++; $display("FAIL timeout_resp got=%h exp=%h",
            {o_DM_data_ready, o_bus_err, o_IC_MemReady, o_DM_ReadData}, {3'b110, 32'h0});
        end
        checks++;
        if (hi != TO) begin
          failures++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", hi, TO);
        end
      end
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL timeout_bound got=no_completion exp=completion");
    end
    tick();
    checks++;
    if ({o_bus_err, o_DM_data_ready} !== 2'b00) begin
      failures++; $display("FAIL timeout_err_pulse got=%b exp=00", {o_bus_err, o_DM_data_ready});
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_IC_DataReq = 1'b1; i_IC_Addr = 32'h300;
    tick();
    tick();
    checks++;
    if (o_MEM_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy got=%b exp=1", o_MEM_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL rstmid_async got=%h exp=0", all_outs());
    end
    i_IC_DataReq = 1'b0;
    tick();
    rst = 1'b0; i_MEM_ack = 1'b1; i_MEM_rdata = 32'h0000_0BAD;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_bus_err} !== 4'b0) begin
        failures++; $display("FAIL rstmid_late_ack cyc=%0d got=%b exp=0000", k,
                             {o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_bus_err});
      end
    end
    i_MEM_ack = 1'b0; i_IC_DataReq = 1'b1; i_IC_Addr = 32'h300;
    tick();
    i_MEM_ack = 1'b1; i_MEM_rdata = 32'h77;
    tick();
    i_MEM_ack = 1'b0; i_IC_DataReq = 1'b0;
    checks++;
    if ({o_IC_MemReady, o_IC_Data, o_bus_err} !== {1'b1, 32'h77, 1'b0}) begin
      failures++; $display("FAIL rstmid_reissue got=%h exp=%h", {o_IC_MemReady, o_IC_Data, o_bus_err},
                           {1'b1, 32'h77, 1'b0});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc, nrdy, wcnt, last_rdy, extra;
    bit prev_req;
    logic [31:0] exp_addr;
    cyc = 0; nrdy = 0; wcnt = 0; last_rdy = 0; extra = 0; prev_req = 1'b0;
    do_reset();
    exp_addr = 32'h400;
    i_IC_DataReq = 1'b1; i_IC_Addr = exp_addr;
    for (int k = 0; k < 80 && nrdy < 3; k++) begin
      tick();
      cyc++;
      i_MEM_ack = 1'b0;
      if (o_IC_MemReady) begin
        checks++;
        if ({o_IC_Data, o_bus_err, o_DM_data_ready} !== {mdata(exp_addr), 2'b00} || wcnt != 6) begin
          failures++; $display("FAIL b2b_ready n=%0d got=%h/%0d exp=%h/6", nrdy,
                               {o_IC_Data, o_bus_err, o_DM_data_ready}, wcnt, {mdata(exp_addr), 2'b00});
        end
        nrdy++;
        last_rdy = cyc;
        exp_addr = 32'h400 + 32'(4 * nrdy);
        if (nrdy < 3) i_IC_Addr = exp_addr;
        else i_IC_DataReq = 1'b0;
      end
      if (o_MEM_req) begin
        if (!prev_req) begin
          checks++;
          if (o_MEM_addr !== exp_addr || (nrdy > 0 && cyc - last_rdy != 2) || (nrdy == 0 && cyc != 1)) begin
            failures++; $display("FAIL b2b_start n=%0d got=%h@%0d exp=%h@%0d", nrdy, o_MEM_addr,
                                 cyc, exp_addr, (nrdy > 0) ? last_rdy + 2 : 1);
          end
          wcnt = 0;
        end
        wcnt++;
        if (wcnt == 6) begin
          i_MEM_ack = 1'b1; i_MEM_rdata = mdata(exp_addr);
        end
      end
      prev_req = o_MEM_req;
    end
    checks++;
    if (nrdy != 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", nrdy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_IC_MemReady || o_DM_data_ready || o_MEM_req) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL b2b_no_duplicate got=%0d exp=0", extra);
    end
  endtask

  task automatic test_random;
    int m_phase, m_wait, m_lat, r;
    bit m_side, m_last, m_to, ic_on, dm_on;
    logic [31:0] s_addr, s_wd, exp_ic, exp_dm;
    logic s_we;
    logic [3:0] s_be;
    do_reset();
    m_phase = 0; m_wait = 0; m_lat = 0; m_side = 1'b0; m_last = 1'b1; m_to = 1'b0;
    s_addr = '0; s_wd = '0; s_we = 1'b0; s_be = '0; exp_ic = '0; exp_dm = '0;
    for (int c = 0; c < 800; c++) begin
      checks++;
      if (o_MEM_req !== (m_phase == 1)) begin
        failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, o_MEM_req, m_phase == 1);
      end
      if (m_phase == 1 && m_wait == 0) begin
        checks++;
        if ({o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en} !== {s_we, s_addr, s_wd, s_be}) begin
          failures++; $display("FAIL rnd_grant cyc=%0d got=%h exp=%h", c,
            {o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en}, {s_we, s_addr, s_wd, s_be});
        end
      end
      checks++;
      if ({o_IC_MemReady, o_DM_data_ready, o_bus_err} !==
          {m_phase == 2 && !m_side, m_phase == 2 && m_side, m_phase == 2 && m_to}) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c,
          {o_IC_MemReady, o_DM_data_ready, o_bus_err},
          {m_phase == 2 && !m_side, m_phase == 2 && m_side, m_phase == 2 && m_to});
      end
      if (m_phase == 2) begin
        checks++;
        if ({o_IC_Data, o_DM_ReadData} !== {exp_ic, exp_dm}) begin
          failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c,
                               {o_IC_Data, o_DM_ReadData}, {exp_ic, exp_dm});
        end
      end
      // Requesters: the completing side may chain a new request straight away.
      if (m_phase == 2 && !m_side) i_IC_DataReq = 1'b0;
      if (m_phase == 2 && m_side) begin i_DM_MemRead = 1'b0; i_DM_Wen = 1'b0; end
      ic_on = i_IC_DataReq;
      dm_on = i_DM_MemRead | i_DM_Wen;
      if (!ic_on && $urandom_range(2) == 0) begin
        i_IC_DataReq = 1'b1; i_IC_Addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_on && $urandom_range(2) == 0) begin
        i_DM_Wen = 1'($urandom_range(1));
        i_DM_MemRead = i_DM_Wen ? 1'($urandom_range(1)) : 1'b1;
        i_DM_Addr = $urandom & 32'hFFFF_FFFC; i_DM_Wd = $urandom; i_DM_byte_en = 4'($urandom);
      end
      if (m_phase == 1) begin
        i_MEM_ack = (m_wait == m_lat);
        i_MEM_rdata = i_MEM_ack ? mdata(s_addr) : $urandom;
      end else begin
        i_MEM_ack = 1'($urandom_range(1));
        i_MEM_rdata = $urandom;
      end
      case (m_phase)
        0: if (i_IC_DataReq || i_DM_MemRead || i_DM_Wen) begin
          m_side = (i_IC_DataReq && (i_DM_MemRead || i_DM_Wen)) ? !m_last : !i_IC_DataReq;
          m_last = m_side;
          if (!m_side) begin s_we = 1'b0; s_addr = i_IC_Addr; s_wd = '0; s_be = 4'hF; end
          else begin s_we = i_DM_Wen; s_addr = i_DM_Addr; s_wd = i_DM_Wd; s_be = i_DM_byte_en; end
          r = $urandom_range(9);
          m_lat = (r < 7) ? r % 4 : (r == 7) ? TO - 1 : (r == 8) ? 4 : 99;
          m_wait = 0;
          m_phase = 1;
        end
        1: if (m_wait == m_lat) begin
          m_phase = 2; m_to = 1'b0;
          if (!m_side) exp_ic = mdata(s_addr);
          else if (!s_we) exp_dm = mdata(s_addr);
        end else if (m_wait == TO - 1) begin
          m_phase = 2; m_to = 1'b1;
          if (!m_side) exp_ic = '0; else exp_dm = '0;
        end else m_wait++;
        default: m_phase = 0;
      endcase
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_lone_i();
    test_tie();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
